// File: rtl/demux_scan_sequencer_pkg.sv
// demux_scan_sequencer_pkg: shared channel constants and FSM state encoding for the demux scan sequencer
package demux_scan_sequencer_pkg;
  localparam int DEMUX_CH = 16;
  localparam int DEMUX_SEL_W = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;
endpackage

// File: rtl/demux_scan_sequencer_lowest_set_16.sv
// lowest_set_16: 16-bit lowest-set-bit priority encoder (idx of lowest 1, any = nonzero)
module lowest_set_16
  import demux_scan_sequencer_pkg::*;
(
  input  logic [DEMUX_CH-1:0]    v,
  output logic [DEMUX_SEL_W-1:0] idx,
  output logic                   any
);
  always_comb begin
    idx = '0;
    for (int i = DEMUX_CH - 1; i >= 0; i--) idx = v[i] ? i[DEMUX_SEL_W-1:0] : idx;
  end
  assign any = |v;
endmodule

// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer: walks masked channels lowest-first, holding each dwell+1 cycles on the demux select/enable/data
module demux_scan_sequencer
  import demux_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEMUX_CH-1:0]    in_data,
  input  logic [DEMUX_CH-1:0]    in_mask,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   abort,
  output logic [DEMUX_SEL_W-1:0] sel,
  output logic                   enable,
  output logic                   demux_in,
  output logic                   busy,
  output logic                   done
);
  localparam logic [DWELL_W-1:0] ONE = 1;
  state_t                   state, state_n;
  logic [DEMUX_CH-1:0]      data_q, data_n, pending, pend_n, ch_bit;
  logic [DWELL_W-1:0]       dwell_q, dwell_n, cnt, cnt_n;
  logic [DEMUX_SEL_W-1:0]   ch, sel_n;
  logic                     pend_any, last, en_n, din_n, fin, fin_n;
  lowest_set_16 u_lsb (.v(pending), .idx(ch), .any(pend_any));
  assign ch_bit = DEMUX_CH'(1) << ch;
  assign last = pending == ch_bit;
  assign in_ready = state == ST_IDLE;
  always_comb begin
    state_n = state;
    data_n = data_q;
    pend_n = pending;
    dwell_n = dwell_q;
    cnt_n = cnt;
    sel_n = sel;
    en_n = 1'b0;
    din_n = 1'b0;
    fin_n = 1'b0;
    if (state == ST_IDLE) begin
      if (in_valid) begin
        data_n = in_data;
        pend_n = in_mask;
        dwell_n = dwell;
        cnt_n = dwell;
        state_n = |in_mask ? ST_SCAN : ST_IDLE;
        fin_n = ~|in_mask;
      end
    end else if (abort || !pend_any) begin
      state_n = ST_IDLE;
      pend_n = '0;
    end else begin
      sel_n = ch;
      en_n = 1'b1;
      din_n = data_q[ch];
      cnt_n = cnt - ONE;
      if (cnt == '0) begin
        pend_n = pending & ~ch_bit;
        cnt_n = dwell_q;
        state_n = last ? ST_IDLE : ST_SCAN;
        fin_n = last;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      data_q <= '0;
      pending <= '0;
      dwell_q <= '0;
      cnt <= '0;
      fin <= 1'b0;
      sel <= '0;
      enable <= 1'b0;
      demux_in <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      data_q <= data_n;
      pending <= pend_n;
      dwell_q <= dwell_n;
      cnt <= cnt_n;
      fin <= fin_n;
      sel <= sel_n;
      enable <= en_n;
      demux_in <= din_n;
      busy <= en_n;
      done <= fin;
    end
  end
endmodule
